// File: rtl/cs_pkg.sv
// Shared widths and state encoding for the CS sliding-window stream driver.
package cs_pkg;

    localparam int CS_XW  = 8;
    localparam int CS_YW  = 10;
    localparam int CS_WIN = 9;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } cs_drv_state_t;

endpackage

// File: rtl/cs_stream_driver_if.sv
// ROM, CS X/Y and status bundle between the stream driver and its surroundings.
interface cs_stream_driver_if #(
    parameter int AW   = 15,
    parameter int ERRW = 16
);
    import cs_pkg::*;

    logic                 start;
    logic [AW-1:0]        in_addr;
    logic [CS_XW-1:0]     in_data;
    logic [AW-1:0]        gold_addr;
    logic [CS_YW-1:0]     gold_data;
    logic [CS_XW-1:0]     X;
    logic [CS_YW-1:0]     Y;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERRW-1:0]      err_cnt;
    logic                 err_flag;
    logic [AW-1:0]        err_idx;

    modport master (
        input  start, in_data, gold_data, Y,
        output in_addr, gold_addr, X, busy, done, pass, err_cnt, err_flag, err_idx
    );

    modport slave (
        output start, in_data, gold_data, Y,
        input  in_addr, gold_addr, X, busy, done, pass, err_cnt, err_flag, err_idx
    );

endinterface

// File: rtl/cs_golden_cmp.sv
// Compares CS output against golden data; keeps a saturating error count,
// a one-cycle mismatch pulse and the index of the first failing window.
module cs_golden_cmp
    import cs_pkg::*;
#(
    parameter int AW   = 15,
    parameter int ERRW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             cmp_en,
    input  logic [CS_YW-1:0] y,
    input  logic [CS_YW-1:0] gold,
    input  logic [AW-1:0]    win_idx,
    output logic [ERRW-1:0]  err_cnt,
    output logic             err_flag,
    output logic [AW-1:0]    err_idx
);

    logic mismatch;

    assign mismatch = cmp_en && (y != gold);

    // err_idx latches only while the count is still zero, so it keeps the first failure.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
            err_idx  <= '0;
        end else begin
            err_flag <= mismatch;
            if (mismatch) begin
                if (err_cnt != '1)
                    err_cnt <= err_cnt + ERRW'(1);
                if (err_cnt == '0)
                    err_idx <= win_idx;
            end
        end
    end

endmodule

// File: rtl/cs_stream_driver.sv
// Streams the sample ROM onto CS X one sample per cycle and checks CS Y
// against the golden ROM, window by window, as an on-chip self-test.
module cs_stream_driver
    import cs_pkg::*;
#(
    parameter int N_PAT = 2000,
    parameter int WIN   = CS_WIN,
    parameter int LAT   = 1,
    parameter int AW    = 15,
    parameter int ERRW  = 16
) (
    input  logic                clk,
    input  logic                reset,
    cs_stream_driver_if.master  bus
);

    if (N_PAT >= (1 << AW) || WIN > N_PAT || WIN + LAT < 2) begin : g_bad_params
        $error("cs_stream_driver: need N_PAT < 2**AW, WIN <= N_PAT and WIN+LAT >= 2");
    end

    // t counts edges since the start edge minus one; every window event is keyed off it.
    localparam logic [AW:0]   T_ONE     = (AW+1)'(1);
    localparam logic [AW:0]   T_LAST    = (AW+1)'(N_PAT - 1);
    localparam logic [AW:0]   T_END     = (AW+1)'(N_PAT + LAT);
    localparam logic [AW:0]   T_CMP_LO  = (AW+1)'(WIN + LAT - 1);
    localparam logic [AW:0]   T_CMP_HI  = (AW+1)'(N_PAT + LAT - 1);
    localparam logic [AW:0]   T_GOLD_LO = (AW+1)'(WIN + LAT - 2);
    localparam logic [AW:0]   T_GOLD_HI = (AW+1)'(N_PAT + LAT - 2);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    cs_drv_state_t     state;
    cs_drv_state_t     state_next;
    logic [AW:0]       t;
    logic [CS_XW-1:0]  x_q;
    logic [AW-1:0]     in_addr_q;
    logic [AW-1:0]     gold_addr_q;
    logic              busy_w;
    logic              done_w;
    logic              accept;
    logic              cmp_en;
    logic              gold_step;
    logic [AW-1:0]     win_idx;
    logic [ERRW-1:0]   err_cnt_w;
    logic              err_flag_w;
    logic [AW-1:0]     err_idx_w;

    assign accept    = bus.start && (state == IDLE || state == DONE);
    assign cmp_en    = busy_w && (t >= T_CMP_LO) && (t <= T_CMP_HI);
    assign gold_step = busy_w && (t >= T_GOLD_LO) && (t <= T_GOLD_HI);
    // gold_addr has already stepped past the window being compared.
    assign win_idx   = gold_addr_q - ADDR_ONE;

    // Next-state and status decode.
    always_comb begin
        state_next = state;
        busy_w     = 1'b0;
        done_w     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_next = STREAM;
            end
            STREAM: begin
                busy_w = 1'b1;
                if (t == T_LAST)
                    state_next = DRAIN;
            end
            DRAIN: begin
                busy_w = 1'b1;
                if (t == T_END)
                    state_next = DONE;
            end
            DONE: begin
                done_w = 1'b1;
                if (bus.start)
                    state_next = STREAM;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sequencing, ROM addressing and X register; addresses return to 0 so the next
    // start finds mem[0] already on in_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            t           <= '0;
            x_q         <= '0;
            in_addr_q   <= '0;
            gold_addr_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        t           <= '0;
                        in_addr_q   <= ADDR_ONE;
                        gold_addr_q <= '0;
                    end
                end
                STREAM: begin
                    t         <= t + T_ONE;
                    x_q       <= bus.in_data;
                    in_addr_q <= (t == T_LAST) ? '0 : in_addr_q + ADDR_ONE;
                    if (gold_step)
                        gold_addr_q <= gold_addr_q + ADDR_ONE;
                end
                DRAIN: begin
                    t <= t + T_ONE;
                    if (t == T_END)
                        gold_addr_q <= '0;
                    else if (gold_step)
                        gold_addr_q <= gold_addr_q + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

    cs_golden_cmp #(
        .AW   (AW),
        .ERRW (ERRW)
    ) u_cmp (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .cmp_en   (cmp_en),
        .y        (bus.Y),
        .gold     (bus.gold_data),
        .win_idx  (win_idx),
        .err_cnt  (err_cnt_w),
        .err_flag (err_flag_w),
        .err_idx  (err_idx_w)
    );

    assign bus.X         = x_q;
    assign bus.in_addr   = in_addr_q;
    assign bus.gold_addr = gold_addr_q;
    assign bus.busy      = busy_w;
    assign bus.done      = done_w;
    assign bus.pass      = done_w && (err_cnt_w == '0);
    assign bus.err_cnt   = err_cnt_w;
    assign bus.err_flag  = err_flag_w;
    assign bus.err_idx   = err_idx_w;

endmodule
